// File: rtl/step_ctrl_pkg.sv
// Shared types for the CPU execution-rate controller: board switch modes,
// controller FSM states and the input synchronizer depth.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT    = 2'b00,
        RUN     = 2'b01,
        STEP    = 2'b10,
        RUN_BRK = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_e;

    localparam int SYNC_DEPTH = 2;

    // Both run modes share S_RUN; the breakpoint check is qualified by the mode itself.
    function automatic state_e mode_target(input mode_e m);
        case (m)
            RUN, RUN_BRK: return S_RUN;
            STEP:         return S_STEP;
            default:      return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizer, stability counter and a one-cycle
// pulse on each accepted press (release produces nothing).
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_DEPTH-1:0] sync_ff;
    logic                  btn_s;
    logic [CW-1:0]         stable_cnt;
    logic                  level;
    logic                  level_d;

    assign btn_s = sync_ff[SYNC_DEPTH-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff    <= '0;
            stable_cnt <= '0;
            level      <= 1'b0;
            level_d    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_DEPTH-2:0], btn};
            level_d <= level;
            // The level flips only after DEB_CYCLES consecutive samples disagree with it.
            if (btn_s == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
                level      <= btn_s;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution-rate controller: issues one-cycle cpu_en strobes for halt, divided
// free-run, button single-step and run-until-breakpoint operation.
module cpu_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH  = 25,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic                 step_btn,
    input  logic [31:0]          pc,
    input  logic [31:0]          break_pc,
    output logic                 cpu_en,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic                 at_break,
    output logic [1:0]           state_o
);

    logic [SYNC_DEPTH-1:0][1:0] mode_ff;
    mode_e                      mode_sync;
    mode_e                      mode_prev;
    mode_e                      mode_q;
    logic                       step_req;
    logic [DIV_WIDTH-1:0]       div_cnt;
    logic                       tick;
    logic                       div_clr;
    state_e                     state;
    state_e                     next_state;
    state_e                     target;
    logic                       next_en;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .pulse (step_req)
    );

    assign mode_sync = mode_e'(mode_ff[SYNC_DEPTH-1]);

    // Switch bounce is filtered by requiring two equal synchronized samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_ff   <= '0;
            mode_prev <= HALT;
            mode_q    <= HALT;
        end else begin
            mode_ff   <= {mode_ff[SYNC_DEPTH-2:0], mode};
            mode_prev <= mode_sync;
            if (mode_sync == mode_prev) mode_q <= mode_sync;
        end
    end

    assign tick    = &div_cnt;
    assign div_clr = (next_state == S_RUN) && (state != S_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       div_cnt <= '0;
        else if (div_clr) div_cnt <= '0;
        else              div_cnt <= div_cnt + DIV_WIDTH'(1);
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_en    = 1'b0;
        target     = mode_target(mode_q);
        case (state)
            S_HALT: next_state = target;
            S_RUN: begin
                if (target != S_RUN) begin
                    next_state = target;
                end else if (tick) begin
                    if (mode_q == RUN_BRK && pc == break_pc) next_state = S_BREAK;
                    else                                     next_en    = 1'b1;
                end
            end
            S_STEP: begin
                if (target != S_STEP) next_state = target;
                else if (step_req)    next_en    = 1'b1;
            end
            S_BREAK: begin
                if (mode_q != RUN_BRK) begin
                    next_state = target;
                end else if (step_req) begin
                    next_en    = 1'b1;
                    next_state = S_RUN;
                end
            end
            default: next_state = S_HALT;
        endcase
        // Guarantees a gap cycle between strobes whatever the request sources do.
        if (cpu_en) next_en = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_HALT;
            cpu_en <= 1'b0;
        end else begin
            state  <= next_state;
            cpu_en <= next_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instr_cnt <= '0;
        else if (cpu_en) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end

    assign at_break = (state == S_BREAK);
    assign state_o  = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a short divider and debounce window.
module tb_cpu_step_ctrl;

    localparam int DIV_WIDTH  = 4;
    localparam int DEB_CYCLES = 4;
    localparam int CNT_WIDTH  = 16;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [1:0]  mode     = 2'b00;
    logic        step_btn = 1'b0;
    logic [31:0] pc       = 32'h0;
    logic [31:0] break_pc = 32'h0;

    logic                 cpu_en;
    logic [CNT_WIDTH-1:0] instr_cnt;
    logic                 at_break;
    logic [1:0]           state_o;

    // Narrow-counter copy used to reach the all-ones wrap in a short run.
    logic [1:0] mode_w = 2'b00;
    logic       cpu_en_w;
    logic [3:0] instr_cnt_w;
    logic       at_break_w;
    logic [1:0] state_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .DIV_WIDTH (DIV_WIDTH),
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .step_btn (step_btn),
        .pc       (pc),
        .break_pc (break_pc),
        .cpu_en   (cpu_en),
        .instr_cnt(instr_cnt),
        .at_break (at_break),
        .state_o  (state_o)
    );

    cpu_step_ctrl #(
        .DIV_WIDTH (DIV_WIDTH),
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_WIDTH (4)
    ) u_wrap (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode_w),
        .step_btn (1'b0),
        .pc       (32'h0),
        .break_pc (32'h0),
        .cpu_en   (cpu_en_w),
        .instr_cnt(instr_cnt_w),
        .at_break (at_break_w),
        .state_o  (state_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (cpu_en === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (state_o === s) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (cpu_en === 1'b1) pulses++;
        end
    endtask

    task automatic wait_en_w(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (cpu_en_w === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int c;
        int p;
        int p2;
        int found;

        // Reset state
        cyc(2);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_instr_cnt", 32'(instr_cnt), 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_at_break", 32'(at_break), 0);
        reset = 1'b1;
        count_pulses(20, p);
        check("halt_no_pulses", p, 0);

        // Free run: 2 sync + 2 qualify + 1 register cycles to enter S_RUN, then 16-cycle period
        mode = 2'b01;
        wait_state(2'd1, 20, c);
        check("run_entry_latency", c, 5);
        wait_en(40, c);
        check("run_first_pulse", c, 16);
        for (int k = 2; k <= 5; k++) begin
            wait_en(40, c);
            check("run_gap", c, 16);
        end
        check("run_cnt_during_5th", 32'(instr_cnt), 4);
        cyc(1);
        check("run_width", 32'(cpu_en), 0);
        check("run_cnt_after_5th", 32'(instr_cnt), 5);

        // Reset asserted while a pulse is high
        wait_en(40, c);
        check("run_gap_6th", c, 15);
        #1 reset = 1'b0;
        #1;
        check("midpulse_rst_cpu_en", 32'(cpu_en), 0);
        check("midpulse_rst_cnt", 32'(instr_cnt), 0);
        check("midpulse_rst_state", 32'(state_o), 0);
        mode = 2'b00;
        cyc(2);
        reset = 1'b1;
        cyc(6);
        check("post_rst_state", 32'(state_o), 0);
        check("post_rst_cnt", 32'(instr_cnt), 0);

        // Single-step with a bouncing press, then a short glitch
        mode = 2'b10;
        wait_state(2'd2, 20, c);
        check("step_entry_latency", c, 5);
        step_btn = 1'b1; cyc(1);
        step_btn = 1'b0; cyc(1);
        step_btn = 1'b1; cyc(1);
        count_pulses(20, p);
        step_btn = 1'b0;
        count_pulses(15, p2);
        check("step_bounce_pulses", p + p2, 1);
        check("step_cnt", 32'(instr_cnt), 1);
        step_btn = 1'b1;
        count_pulses(2, p);
        step_btn = 1'b0;
        count_pulses(15, p2);
        check("step_glitch_pulses", p + p2, 0);

        // Step request lands on a divider tick: press 10 cycles after a tick so the
        // debounced edge (6 cycles after the press) coincides with the next tick.
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.tick === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("tick_seen", found, 1);
        cyc(10);
        step_btn = 1'b1;
        cyc(6);
        check("align_req_tick", {30'd0, dut.step_req, dut.tick}, 32'd3);
        step_btn = 1'b0;
        count_pulses(25, p);
        check("same_cycle_pulses", p, 1);
        check("same_cycle_cnt", 32'(instr_cnt), 2);

        // Switch to HALT; a press afterwards gives nothing
        mode = 2'b00;
        wait_state(2'd0, 20, c);
        check("halt_entry_latency", c, 5);
        step_btn = 1'b1;
        count_pulses(10, p);
        step_btn = 1'b0;
        count_pulses(20, p2);
        check("halt_press_pulses", p + p2, 0);

        // Run to breakpoint: the core model advances pc by 4 per pulse
        break_pc = 32'h10;
        pc       = 32'h0;
        mode     = 2'b11;
        wait_state(2'd1, 20, c);
        check("brk_entry_latency", c, 5);
        for (int k = 0; k < 4; k++) begin
            wait_en(40, c);
            check("brk_run_gap", c, 16);
            pc = pc + 32'd4;
        end
        wait_state(2'd3, 40, c);
        check("brk_hit_time", c, 16);
        check("brk_no_pulse", 32'(cpu_en), 0);
        check("brk_at_break", 32'(at_break), 1);
        check("brk_cnt", 32'(instr_cnt), 6);
        count_pulses(40, p);
        check("brk_parked_pulses", p, 0);
        check("brk_parked_state", 32'(state_o), 3);

        step_btn = 1'b1;
        wait_en(20, c);
        check("brk_step_latency", c, 7);
        check("brk_step_at_break", 32'(at_break), 0);
        check("brk_step_state", 32'(state_o), 1);
        pc       = 32'h14;
        step_btn = 1'b0;
        wait_en(40, c);
        check("brk_resume_gap", c, 16);
        check("brk_resume_cnt", 32'(instr_cnt), 7);
        mode = 2'b00;
        cyc(8);

        // Counter wrap on the 4-bit copy: 15 pulses reach all ones, the 16th wraps to 0
        mode_w = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            wait_en_w(40, c);
            check("wrap_pulse_seen", 32'(c > 0), 1);
        end
        cyc(1);
        check("wrap_all_ones", 32'(instr_cnt_w), 32'hF);
        check("wrap_state", 32'(state_w), 1);
        check("wrap_at_break", 32'(at_break_w), 0);
        wait_en_w(40, c);
        check("wrap_gap", c, 15);
        cyc(1);
        check("wrap_to_zero", 32'(instr_cnt_w), 0);
        mode_w = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
